// File: rtl/fma_share_sched_if.sv
// fma_share_sched_if: requester-side operand and result handshakes of the shared FMA scheduler
interface fma_share_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*32-1:0] req_c;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [31:0]           resp_data;
  modport master (
    output req_valid, req_a, req_b, req_c, resp_ready,
    input  req_ready, resp_valid, resp_data
  );
  modport slave (
    input  req_valid, req_a, req_b, req_c, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/fma_share_sched.sv
// fma_share_sched: round-robin sharing of one multicycle combinational FMA among NUM_REQ requesters
module fma_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int FMA_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  fma_share_sched_if.slave bus,
  output logic [31:0]      fma_a,
  output logic [31:0]      fma_b,
  output logic [31:0]      fma_c,
  input  logic [31:0]      fma_result,
  output logic             busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FMA_LAT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t             r_state, w_next;
  logic [PW-1:0]      r_ptr, r_owner, w_gnt;
  logic [CW-1:0]      r_cnt;
  logic               w_any, w_acc;
  logic [31:0]        r_a, r_b, r_c, r_data;
  logic [NUM_REQ-1:0] r_resp_valid;
  // the lowest offset from r_ptr wins, so scan from the far end down
  always_comb begin
    w_gnt = '0;
    w_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[(int'(r_ptr) + i) % NUM_REQ]) begin
        w_gnt = PW'((int'(r_ptr) + i) % NUM_REQ);
        w_any = 1'b1;
      end
  end
  assign w_acc = r_state == IDLE && w_any;
  always_comb begin
    w_next = (w_acc) ? EXEC :
             (r_state == EXEC && r_cnt == '0) ? RESP :
             (r_state == RESP && bus.resp_ready[r_owner]) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_data       <= '0;
      r_resp_valid <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a     <= bus.req_a[32*w_gnt +: 32];
        r_b     <= bus.req_b[32*w_gnt +: 32];
        r_c     <= bus.req_c[32*w_gnt +: 32];
        r_owner <= w_gnt;
        r_ptr   <= (w_gnt == PW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
        r_cnt   <= CW'(FMA_LAT - 1);
      end
      if (r_state == EXEC) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else begin
          r_data       <= fma_result;
          r_resp_valid <= NUM_REQ'(1) << r_owner;
        end
      end
      if (r_state == RESP && bus.resp_ready[r_owner]) r_resp_valid <= '0;
    end
  assign bus.req_ready  = w_acc ? NUM_REQ'(1) << w_gnt : '0;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_data;
  assign fma_a          = r_a;
  assign fma_b          = r_b;
  assign fma_c          = r_c;
  assign busy           = r_state != IDLE;
endmodule

// File: tb/tb_fma_share_sched.sv
// tb_fma_share_sched: scoreboard bench with an XOR FMA stub; second instance rebuilt with FMA_LAT=1
module tb_fma_share_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fma_a, fma_b, fma_c, fma_res, fma2_a, fma2_b, fma2_c, fma2_res;
  logic        busy, busy2;
  logic [31:0] op_a [4], op_b [4], op_c [4];
  int          cyc = 0, n_chk = 0, n_fail = 0, last_acc = -1;
  typedef struct {int o; logic [31:0] d; logic [31:0] a;} exp_t;
  exp_t sb[$];
  fma_share_sched_if #(.NUM_REQ(4)) bus ();
  fma_share_sched_if #(.NUM_REQ(4)) bus2 ();
  fma_share_sched #(.NUM_REQ(4), .FMA_LAT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_result(fma_res), .busy(busy));
  fma_share_sched #(.NUM_REQ(4), .FMA_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .fma_a(fma2_a), .fma_b(fma2_b), .fma_c(fma2_c),
    .fma_result(fma2_res), .busy(busy2));
  assign fma_res  = fma_a ^ fma_b ^ fma_c;
  assign fma2_res = fma2_a ^ fma2_b ^ fma2_c;
  assign bus.req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign bus.req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
  assign bus.req_c = {op_c[3], op_c[2], op_c[1], op_c[0]};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // caller must be just past a rising edge; keep is the request mask left after the accept
  task automatic txn(input logic [3:0] mask, input int g, input logic [3:0] keep,
                     input int stall, input bit chk_gap);
    int n, acc;
    exp_t e;
    logic [31:0] d0;
    bus.req_valid = mask;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ready == 4'b0 && n < 20);
    check("grant", 32'(bus.req_ready), 32'(4'b0001 << g));
    sb.push_back('{g, op_a[g] ^ op_b[g] ^ op_c[g], op_a[g]});
    @(posedge clk); #1;
    acc = cyc;
    bus.req_valid = keep;
    if (chk_gap && last_acc >= 0) check("issue_gap", 32'(acc - last_acc), 32'd4);
    last_acc = acc;
    op_a[g] = $urandom; op_b[g] = $urandom; op_c[g] = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.resp_valid == 4'b0 && n < 20);
    check("latency", 32'(cyc - acc), 32'd2);
    if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      check("resp_valid", 32'(bus.resp_valid), 32'(4'b0001 << e.o));
      check("resp_data", bus.resp_data, e.d);
      check("fma_a_held", fma_a, e.a);
    end
    if (stall > 0) begin
      bus.resp_ready = ~(4'b0001 << g);
      d0 = bus.resp_data;
      repeat (stall) begin
        @(negedge clk);
        check("stall_valid", 32'(bus.resp_valid), 32'(4'b0001 << g));
        check("stall_data", bus.resp_data, d0);
        check("stall_ready", 32'(bus.req_ready), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
      end
      bus.req_valid = 4'b0;
      bus.resp_ready = 4'hf;
    end
    @(posedge clk); #1;
    check("resp_clr", 32'(bus.resp_valid), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, acc;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = $urandom;
    end
    op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000; op_c[0] = 32'h4040_0000;
    bus.req_valid = 4'b0;  bus.resp_ready = 4'hf;
    bus2.req_valid = 4'b0; bus2.resp_ready = 4'hf;
    bus2.req_a = {32'h0, 32'h0, 32'h1234_5678, 32'h0};
    bus2.req_b = {32'h0, 32'h0, 32'h0F0F_0F0F, 32'h0};
    bus2.req_c = {32'h0, 32'h0, 32'hA5A5_0000, 32'h0};
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_fma_a", fma_a, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    txn(4'b0001, 0, 4'b0000, 0, 0);
    check("t1_data", bus.resp_data, 32'h3FC0_0000);
    txn(4'b0010, 1, 4'b0000, 0, 0);
    txn(4'b0011, 0, 4'b0010, 0, 0);
    txn(4'b0011, 1, 4'b0000, 0, 0);
    txn(4'b0100, 2, 4'b1111, 10, 0);
    // pointer now 3; requester 2 is granted, then reset lands mid-EXEC
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("t5_grant", 32'(bus.req_ready), 32'b0100);
    @(posedge clk); #1;
    bus.req_valid = 4'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("t5_resp_data", bus.resp_data, 32'd0);
    check("t5_fma_a", fma_a, 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    #3 rst = 1'b0;
    n = 0;
    repeat (6) begin @(negedge clk); if (bus.resp_valid != 4'b0) n++; end
    check("t5_no_resp", 32'(n), 32'd0);
    @(posedge clk); #1;
    last_acc = -1;
    txn(4'b1111, 0, 4'b1111, 0, 1);
    txn(4'b1111, 1, 4'b1111, 0, 1);
    txn(4'b1111, 2, 4'b1111, 0, 1);
    txn(4'b1111, 3, 4'b1111, 0, 1);
    txn(4'b1111, 0, 4'b0000, 0, 1);
    bus2.req_valid = 4'b0010;
    @(negedge clk);
    check("t6_grant", 32'(bus2.req_ready), 32'b0010);
    @(posedge clk); #1;
    acc = cyc;
    bus2.req_valid = 4'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus2.resp_valid == 4'b0 && n < 20);
    check("t6_latency", 32'(cyc - acc), 32'd1);
    check("t6_resp_valid", 32'(bus2.resp_valid), 32'b0010);
    check("t6_resp_data", bus2.resp_data, 32'h1234_5678 ^ 32'h0F0F_0F0F ^ 32'hA5A5_0000);
    @(posedge clk); #1;
    check("t6_resp_clr", 32'(bus2.resp_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
